memory_array_ctrl: RTL and testbench
====================================

Name: memory_array_ctrl

Overview:
- Parametrised word-addressed storage array: DEPTH words of WIDTH bits, behind a single valid/ready request port and a valid/ready response port.
- Supports read, write and a multi-cycle bulk clear.
- Successor to the fixed byte-wide, single-select word; the storage sits behind a sequential controller with backpressure.
- Sits between the bus-side access logic and the bit storage.

Parameters:
- WIDTH, 8, bits per word (>=1)
- DEPTH, 16, number of words (>=2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_op  in  2  00 read, 01 write, 10 clear-all, 11 reserved
- req_addr  in  ADDR_W  word address
- req_wdata  in  WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  WIDTH  read data (0 for non-read ops)
- rsp_err  out  1  addr >= DEPTH, or op 11
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous and active-low on rst_n, released synchronously to clk by the system.
  - On reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0; clear counter=0.
  - Array contents are NOT reset (undefined until written or cleared).
- Handshake:
  - A transfer occurs on a rising edge where valid&&ready.
  - req_ready = (state==IDLE).
  - The response is held stable (rsp_valid, rsp_rdata, rsp_err) until rsp_ready is sampled high.
- FSM states: IDLE, CLEAR, RESP.
  - IDLE, accepted read:
    - rdata <= mem[addr] (or 0 with err=1 if out of range).
    - Go to RESP.
    - Latency: rsp_valid rises the cycle after acceptance.
  - IDLE, accepted write:
    - mem[addr] <= wdata at the accepting edge, suppressed if out of range (err=1).
    - rdata=0. Go to RESP.
  - IDLE, accepted clear:
    - Counter <= 0. Go to CLEAR. req_addr and req_wdata are ignored.
  - IDLE, accepted op 11: no array effect, err=1, go to RESP.
  - CLEAR:
    - Each cycle mem[counter] <= 0; counter++.
    - When counter==DEPTH-1, write the last word and go to RESP (err=0, rdata=0).
    - Exactly DEPTH cycles in CLEAR.
  - RESP:
    - rsp_valid=1.
    - On rsp_ready go to IDLE; rsp_valid drops the next cycle.
    - One accepted request yields exactly one response.
- Boundaries:
  - Max throughput is one op per 2 cycles when rsp_ready is held high; no request acceptance while a response is pending.
  - Read-after-write to the same address returns the new data (the write completes before the next request is accepted).
  - Out-of-range check compares the full ADDR_W address against DEPTH; relevant when DEPTH is not a power of two.
  - rsp_ready held low indefinitely: stall in RESP with outputs stable; no array changes.
  - Reset mid-CLEAR: the clear is aborted; words not yet cleared keep prior contents; return to IDLE with reset outputs.
  - req_valid while busy: ignored; the requester must hold it (standard valid/ready).

Decomposition:
- Package mem_pkg:
  - typedef enum {IDLE, CLEAR, RESP} for state.
  - localparams OP_READ=2'b00, OP_WRITE=2'b01, OP_CLEAR=2'b10.
- One natural sub-module: mem_storage, a parametrised WIDTH x DEPTH array.
  - One write port: we, waddr, wdata.
  - One asynchronous read port.
  - No reset.
- The controller instantiates mem_storage and muxes its write port between request data and the clear counter.

Test Plan:
- Reset, then write 0xA5 to addr 3, then read addr 3:
  - Both requests accepted in IDLE.
  - Read rsp_valid rises the cycle after acceptance with rdata=0xA5, err=0.
- Write addr 0..15 with value (addr*17), issue clear, then read all 16:
  - busy high for exactly 16 cycles in CLEAR plus the RESP cycle(s).
  - Every read returns 0x00.
- DEPTH=12, read addr 13:
  - rsp_err=1, rdata=0.
  - A subsequent read of addr 11 is unaffected (err=0).
- Backpressure: read addr 3 with rsp_ready held low for 5 cycles:
  - rsp_valid and rdata stay stable.
  - req_ready stays 0.
  - After rsp_ready=1, req_ready returns to 1 the next cycle.
- Assert rst_n low during cycle 4 of a clear after filling memory with 0xFF:
  - Outputs go to reset values immediately (asynchronous).
  - Reads afterward: addr 0..3 return 0x00, addr 4..15 return 0xFF.
- Back-to-back: write addr 7 = 0x3C, then immediately read addr 7 with rsp_ready tied high:
  - Read returns 0x3C.
  - One response per request; requests accepted every 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and opcodes for the word storage controller.
// Imported by the controller and its storage array.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RESP
  } state_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

endpackage

// File: rtl/mem_storage.sv
// WIDTH x DEPTH word array, one synchronous write port,
// one asynchronous read port, no reset.
module mem_storage #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/memory_array_ctrl.sv
// Sequential controller for the word array: read, write and
// multi-cycle bulk clear behind valid/ready request/response ports.
module memory_array_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  mem_rdata;

  logic in_range;
  logic op_rd, op_wr, op_clr;
  logic cnt_last;

  // Widened compare so non-power-of-two depths flag the top codes.
  assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign cnt_last = cnt_q == ADDR_W'(DEPTH - 1);

  assign op_rd  = req_op == OP_READ;
  assign op_wr  = req_op == OP_WRITE;
  assign op_clr = req_op == OP_CLEAR;

  mem_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_storage (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(req_addr),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    we      = 1'b0;
    waddr   = req_addr;
    wdata   = req_wdata;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
          unique case (1'b1)
            op_rd: begin
              rdata_d = in_range ? mem_rdata : '0;
              err_d   = !in_range;
            end
            op_wr: begin
              we    = in_range;
              err_d = !in_range;
            end
            op_clr: begin
              cnt_d   = '0;
              state_d = CLEAR;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_memory_array_ctrl.sv
// Directed scoreboard bench for memory_array_ctrl
// (DEPTH=16 and a DEPTH=12 instance).
module tb_memory_array_ctrl;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [1:0] req_op    [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err   [2];
  logic       busy      [2];

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_wait;
  int   busy_cnt;
  time  acc_t = 0;
  time  acc_prev = 0;

  memory_array_ctrl #(.WIDTH(8), .DEPTH(16)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid[0]),
    .req_ready(req_ready[0]),
    .req_op   (req_op[0]),
    .req_addr (req_addr[0]),
    .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]),
    .rsp_err  (rsp_err[0]),
    .busy     (busy[0])
  );

  memory_array_ctrl #(.WIDTH(8), .DEPTH(12)) u_dut12 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid[1]),
    .req_ready(req_ready[1]),
    .req_op   (req_op[1]),
    .req_addr (req_addr[1]),
    .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]),
    .rsp_err  (rsp_err[1]),
    .busy     (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge.
  task automatic xfer(input int s,
                      input logic [1:0] op,
                      input logic [3:0] a,
                      input logic [7:0] wd,
                      input logic [7:0] ed,
                      input logic ee,
                      input int stall);
    int n;
    exp_t e;
    q.push_back('{d: ed, e: ee});
    rsp_ready[s] = (stall == 0);
    req_valid[s] = 1'b1;
    req_op[s]    = op;
    req_addr[s]  = a;
    req_wdata[s] = wd;
    n = 0;
    while (!req_ready[s] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 40), 32'd1);
    @(posedge clk);
    acc_prev = acc_t;
    acc_t    = $time;
    @(negedge clk);
    req_valid[s] = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!rsp_valid[s] && n < 40) begin
      if (busy[s]) busy_cnt++;
      @(negedge clk);
      n++;
    end
    last_wait = n;
    chk("rsp_timeout", 32'(n < 40), 32'd1);
    e = q.pop_front();
    chk("rsp_rdata", 32'(rsp_rdata[s]), 32'(e.d));
    chk("rsp_err", 32'(rsp_err[s]), 32'(e.e));
    chk("busy_resp", 32'(busy[s]), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid[s]), 32'd1);
      chk("stall_rdata", 32'(rsp_rdata[s]), 32'(e.d));
      chk("stall_ready", 32'(req_ready[s]), 32'd0);
    end
    rsp_ready[s] = 1'b1;
    @(negedge clk);
    chk("ready_back", 32'(req_ready[s]), 32'd1);
    chk("valid_drop", 32'(rsp_valid[s]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_op[s]    = 2'b00;
      req_addr[s]  = '0;
      req_wdata[s] = '0;
      rsp_ready[s] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata[0]), 32'd0);
    chk("rst_err", 32'(rsp_err[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read, read latency one cycle
    xfer(0, 2'b01, 4'd3, 8'hA5, 8'h00, 1'b0, 0);
    xfer(0, 2'b00, 4'd3, 8'h00, 8'hA5, 1'b0, 0);
    chk("rd_latency", 32'(last_wait), 32'd0);

    // Fill, clear, read back zeros
    for (int a = 0; a < 16; a++)
      xfer(0, 2'b01, 4'(a), 8'(a * 17), 8'h00, 1'b0, 0);
    xfer(0, 2'b00, 4'd5, 8'h00, 8'h55, 1'b0, 0);
    xfer(0, 2'b10, 4'd9, 8'hEE, 8'h00, 1'b0, 0);
    chk("clear_cycles", 32'(busy_cnt), 32'd16);
    for (int a = 0; a < 16; a++)
      xfer(0, 2'b00, 4'(a), 8'h00, 8'h00, 1'b0, 0);

    // Reserved opcode
    xfer(0, 2'b11, 4'd2, 8'h11, 8'h00, 1'b1, 0);

    // DEPTH=12 out-of-range handling
    xfer(1, 2'b01, 4'd11, 8'h5A, 8'h00, 1'b0, 0);
    xfer(1, 2'b00, 4'd13, 8'h00, 8'h00, 1'b1, 0);
    xfer(1, 2'b01, 4'd12, 8'h77, 8'h00, 1'b1, 0);
    xfer(1, 2'b00, 4'd11, 8'h00, 8'h5A, 1'b0, 0);

    // Backpressure
    xfer(0, 2'b01, 4'd3, 8'h96, 8'h00, 1'b0, 0);
    xfer(0, 2'b00, 4'd3, 8'h00, 8'h96, 1'b0, 5);

    // Reset during clear
    for (int a = 0; a < 16; a++)
      xfer(0, 2'b01, 4'(a), 8'hFF, 8'h00, 1'b0, 0);
    req_valid[0] = 1'b1;
    req_op[0]    = 2'b10;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy[0]), 32'd0);
    chk("arst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("arst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("arst_rdata", 32'(rsp_rdata[0]), 32'd0);
    chk("arst_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++)
      xfer(0, 2'b00, 4'(a), 8'h00,
           (a < 4) ? 8'h00 : 8'hFF, 1'b0, 0);

    // Back-to-back write then read
    xfer(0, 2'b01, 4'd7, 8'h3C, 8'h00, 1'b0, 0);
    xfer(0, 2'b00, 4'd7, 8'h00, 8'h3C, 1'b0, 0);
    chk("b2b_spacing", 32'(acc_t - acc_prev), 32'd20);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
